// File: rtl/booth_pkg.sv
// Shared constants and FSM encoding for the booth_mul operand feeder.
package booth_pkg;
  localparam int W           = 5;
  localparam int PROD_W      = 2 * W;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_OPA,
    ST_OPB,
    ST_WAIT
  } state_t;
endpackage

// File: rtl/booth_pair_fifo.sv
// Small synchronous FIFO holding packed {a,b} operand pairs.
module booth_pair_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/booth_operand_feeder.sv
// Buffers operand pairs, serialises them onto booth_mul's inbus and returns
// the product (or a timeout error) on a valid/ready output port.
//
//  state | meaning
//  IDLE  | waiting for a pair, an idle multiplier and a free output register
//  START | start pulse on the bus, inbus = 0
//  OPA   | multiplicand on inbus
//  OPB   | multiplier on inbus
//  WAIT  | waiting for mul_done, bounded by TIMEOUT cycles
module booth_operand_feeder #(
  parameter int W          = booth_pkg::W,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = booth_pkg::TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           mul_start,
  output logic [W-1:0]   mul_inbus,
  input  logic           mul_ready,
  input  logic           mul_done,
  input  logic [2*W-1:0] mul_result,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_product,
  output logic           out_err
);
  import booth_pkg::*;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   op_a, op_b;
  logic [W-1:0]   head_a, head_b;
  logic [2*W-1:0] fifo_rdata;
  logic           fifo_full, fifo_empty;
  logic           push, launch;

  assign in_ready = !fifo_full && !rst;
  assign push     = in_valid && in_ready;
  assign launch   = (state == ST_IDLE) && !fifo_empty && mul_ready && !out_valid;
  assign {head_a, head_b} = fifo_rdata;

  booth_pair_fifo #(
    .DW    (2*W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (launch),
    .wdata ({in_a, in_b}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      mul_start   <= 1'b0;
      mul_inbus   <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_err     <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (launch) begin
            op_a      <= head_a;
            op_b      <= head_b;
            mul_start <= 1'b1;
            mul_inbus <= '0;
            state     <= ST_START;
          end
        end
        ST_START: begin
          mul_start <= 1'b0;
          mul_inbus <= op_a;
          state     <= ST_OPA;
        end
        ST_OPA: begin
          mul_inbus <= op_b;
          state     <= ST_OPB;
        end
        ST_OPB: begin
          mul_inbus <= '0;
          cnt       <= '0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done arriving on the final timeout cycle still yields a product.
          if (mul_done) begin
            out_product <= mul_result;
            out_valid   <= 1'b1;
            out_err     <= 1'b0;
            state       <= ST_IDLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            out_product <= '0;
            out_valid   <= 1'b1;
            out_err     <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_operand_feeder.sv
// Self-checking bench: feeder plus a behavioural booth_mul stand-in.
module tb_booth_operand_feeder;
  localparam int TW  = 5;
  localparam int TO  = 64;
  localparam int LAT = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [TW-1:0]   in_a, in_b;
  logic            mul_start, mul_ready, mul_done;
  logic [TW-1:0]   mul_inbus;
  logic [2*TW-1:0] mul_result;
  logic            out_valid, out_ready, out_err;
  logic [2*TW-1:0] out_product;

  logic            never_done, hold_nr;
  int              mph, mcnt;
  logic signed [TW-1:0] ma, mb;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int qa[$], qb[$];

  always #40 clk = ~clk;

  booth_operand_feeder #(.W(TW), .FIFO_DEPTH(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_start(mul_start), .mul_inbus(mul_inbus),
    .mul_ready(mul_ready), .mul_done(mul_done), .mul_result(mul_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .out_err(out_err)
  );

  // Multiplier stand-in: start, then a, then b, then LAT cycles to a done pulse.
  assign mul_ready = (mph == 0) && !hold_nr;
  always @(posedge clk) begin
    if (rst) begin
      mph        <= 0;
      mcnt       <= 0;
      mul_done   <= 1'b0;
      mul_result <= '0;
    end else begin
      mul_done <= 1'b0;
      case (mph)
        0: if (mul_start) mph <= 1;
        1: begin ma <= mul_inbus; mph <= 2; end
        2: begin mb <= mul_inbus; mcnt <= LAT; mph <= 3; end
        default: begin
          if (mcnt == 0) begin
            mph <= 0;
            if (!never_done) begin
              mul_done   <= 1'b1;
              mul_result <= 10'(int'(ma) * int'(mb));
            end
          end else begin
            mcnt <= mcnt - 1;
          end
        end
      endcase
    end
  end

  function automatic logic [9:0] ref_prod(int a, int b);
    return 10'(a * b);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(int a, int b);
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    check("push_ready", in_ready, 1);
    in_valid = 1'b1;
    in_a     = TW'(a);
    in_b     = TW'(b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(string tag, logic [9:0] exp_p, logic exp_e, int delay);
    int n = 0;
    while (!out_valid && n < 300) begin @(negedge clk); n++; end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_prod"}, out_product, exp_p);
    check({tag, "_err"}, out_err, exp_e);
    repeat (delay) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drop"}, out_valid, 0);
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, "_start"}, mul_start, 0);
    check({tag, "_inbus"}, mul_inbus, 0);
    check({tag, "_ovalid"}, out_valid, 0);
    check({tag, "_oprod"}, out_product, 0);
    check({tag, "_oerr"}, out_err, 0);
    check({tag, "_inready"}, in_ready, 0);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ea, eb, ra, rb;
    logic [9:0] held;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    never_done = 1'b0; hold_nr = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("reset_inready", in_ready, 1);

    // 3 x -2: latency and bus order
    push(3, -2);
    check("t1_start_t1", mul_start, 0);
    @(negedge clk);
    check("t1_start_t2", mul_start, 1);
    check("t1_bus_t2", mul_inbus, 5'h00);
    @(negedge clk);
    check("t1_start_t3", mul_start, 0);
    check("t1_bus_a", mul_inbus, 5'h03);
    @(negedge clk);
    check("t1_bus_b", mul_inbus, 5'h1E);
    @(negedge clk);
    check("t1_bus_wait", mul_inbus, 5'h00);
    collect("t1", 10'h3FA, 1'b0, 0);

    // FIFO fills while the multiplier reports busy
    hold_nr = 1'b1;
    push(-16, -16);
    push(7, 5);
    check("full_inready", in_ready, 0);
    in_valid = 1'b1; in_a = 5'd1; in_b = 5'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("notready_start", mul_start, 0);
    end
    in_valid = 1'b0;
    check("full_inready_hold", in_ready, 0);
    hold_nr = 1'b0;
    collect("t2a", 10'h100, 1'b0, 0);
    collect("t2b", 10'h023, 1'b0, 0);
    repeat (30) @(negedge clk);
    check("t2_no_extra", out_valid, 0);

    // Output held under back-pressure; no new start meanwhile
    push(4, 4);
    push(-3, 5);
    n = 0;
    while (!out_valid && n < 300) begin @(negedge clk); n++; end
    held = out_product;
    check("hold_first", held, 10'h010);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_prod", out_product, 10'h010);
      check("hold_start", mul_start, 0);
    end
    collect("t3a", 10'h010, 1'b0, 0);
    collect("t3b", 10'h3F1, 1'b0, 0);

    // Multiplier that never answers
    never_done = 1'b1;
    push(9, 9);
    n = 0;
    while (!out_valid && n < 300) begin @(negedge clk); n++; end
    check("to_latency", n, 4 + TO);
    collect("to", 10'h000, 1'b1, 2);
    never_done = 1'b0;
    push(6, -3);
    collect("after_to", 10'h3EE, 1'b0, 0);

    // Reset while waiting for done, with a second pair queued
    push(5, 5);
    push(2, 2);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("rstw");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("rstw_idle", mul_start | out_valid, 0);
    end
    push(2, 3);
    collect("rstw_fresh", 10'h006, 1'b0, 0);

    // Reset while the multiplicand is on the bus
    push(-7, 3);
    @(negedge clk);
    @(negedge clk);
    check("rsta_bus_a", mul_inbus, 5'h19);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("rsta");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rsta_idle", mul_start | out_valid, 0);
    end
    push(2, 3);
    collect("rsta_fresh", 10'h006, 1'b0, 0);

    // Random pairs against arithmetic reference
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 2; k++) begin
        ra = int'($urandom_range(0, 31)) - 16;
        rb = int'($urandom_range(0, 31)) - 16;
        qa.push_back(ra);
        qb.push_back(rb);
        push(ra, rb);
      end
      for (int k = 0; k < 2; k++) begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        collect("rnd", ref_prod(ea, eb), 1'b0, int'($urandom_range(0, 3)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
